// File: rtl/as2650_io_pkg.sv
// Shared definitions for the AS2650 I/O responder: status/control bit
// positions and the bus cycle classification.
package as2650_io_pkg;

  // Status byte returned on a control-port read
  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_OVF      = 4;
  localparam int ST_UNF      = 5;
  localparam int ST_IRQ      = 7;

  // Control register bits with a hardware meaning
  localparam int CT_RXFLUSH = 1;
  localparam int CT_TXFLUSH = 2;
  localparam int CT_LOOP    = 3;
  localparam int CT_IRQEN   = 7;

  typedef enum logic [1:0] {
    CYC_NONE = 2'd0,
    CYC_CTRL = 2'd1,
    CYC_DATA = 2'd2
  } cyc_e;

  // Exactly one strobe high selects a port; both high is illegal and maps to none
  function automatic cyc_e cyc_kind(input logic ioc, input logic iod);
    case ({ioc, iod})
      2'b10:   return CYC_CTRL;
      2'b01:   return CYC_DATA;
      default: return CYC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/as2650_io_fifo.sv
// Small byte FIFO with extra-MSB pointers. A pop on empty is ignored, and a
// push on full is accepted only when a pop frees a slot in the same cycle.
// Flush clears both pointers and wins over any push/pop that cycle.
module as2650_io_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  input  logic       i_flush,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_pop_ok;
  logic                w_push_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  // Empty head reads as zero so idle outputs stay deterministic
  assign o_head    = o_empty ? 8'h00 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer update: flush first, otherwise independent push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
  end

endmodule

// File: rtl/as2650_io_responder.sv
// Peripheral end of the AS2650 IOC/IOD strobe protocol. Control cycles hit a
// control/status register pair, data cycles hit a TX FIFO (CPU to device) and
// an RX FIFO (device to CPU).
// Optional: define AS2650_IO_SENSE_IRQ_EN to add the sense_o interrupt output.
module as2650_io_responder
  import as2650_io_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 2,
  parameter logic [7:0] RESET_CTRL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bus_i,
  output logic [7:0] bus_o,
  output logic       bus_oe,
  input  logic       oe_n,
  input  logic       we_n,
  input  logic       ioc,
  input  logic       iod,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] ctrl_q
`ifdef AS2650_IO_SENSE_IRQ_EN
  ,
  output logic       sense_o
`endif
);

  cyc_e       w_cyc, r_rd_cyc;
  logic       w_sel, w_rd, w_commit, w_wr_ctrl, w_wr_data;
  logic       r_we_n_q, r_ovf, r_unf;
  logic [7:0] r_ctrl, w_status, w_rd_data;
  logic       w_lb_push, w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0] w_rx_wdata, w_rx_head;
  logic       w_done, w_done_ctrl, w_done_data, w_ovf_set, w_unf_set, w_irq;

  assign w_cyc     = cyc_kind(ioc, iod);
  assign w_sel     = ioc ^ iod;
  // A write commits only on the we_n falling edge, so one commit per CPU write
  assign w_commit  = w_sel & ~we_n & r_we_n_q;
  assign w_wr_ctrl = w_commit & (w_cyc == CYC_CTRL);
  assign w_wr_data = w_commit & (w_cyc == CYC_DATA);
  assign w_rd      = w_sel & ~oe_n & we_n;

  // Loopback steers CPU data writes into RX; the CPU byte beats upstream
  assign w_lb_push  = w_wr_data & r_ctrl[CT_LOOP];
  assign w_tx_push  = w_wr_data & ~r_ctrl[CT_LOOP];
  assign rx_ready   = ~w_rx_full & ~w_lb_push;
  assign w_rx_push  = w_lb_push | (rx_valid & rx_ready);
  assign w_rx_wdata = w_lb_push ? bus_i : rx_data;
  assign tx_valid   = ~w_tx_empty;
  assign w_tx_pop   = tx_valid & tx_ready;

  // A read completes on the first cycle after the strobe drops
  assign w_done      = (r_rd_cyc != CYC_NONE) & ~w_sel;
  assign w_done_ctrl = w_done & (r_rd_cyc == CYC_CTRL);
  assign w_done_data = w_done & (r_rd_cyc == CYC_DATA);
  assign w_rx_pop    = w_done_data & ~w_rx_empty;
  assign w_unf_set   = w_done_data & w_rx_empty;
  assign w_ovf_set   = (w_tx_push & w_tx_full & ~w_tx_pop) |
                       (w_rx_push & w_rx_full & ~w_rx_pop);

  // Status byte assembly
  always_comb begin
    w_status              = 8'h00;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_OVF]      = r_ovf;
    w_status[ST_UNF]      = r_unf;
    w_status[ST_IRQ]      = w_irq;
  end

  // Read mux: drive is combinational and dies with reset immediately
  assign bus_oe = w_rd & rst_n;
  always_comb begin
    w_rd_data = 8'h00;
    if (bus_oe) w_rd_data = (w_cyc == CYC_CTRL) ? w_status : w_rx_head;
  end
  assign bus_o  = w_rd_data;
  assign ctrl_q = r_ctrl;

  // Bus history: we_n edge detector and kind of the read in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_n_q <= 1'b1;
      r_rd_cyc <= CYC_NONE;
    end else begin
      r_we_n_q <= we_n;
      r_rd_cyc <= w_rd ? w_cyc : CYC_NONE;
    end
  end

  // Control register; flush bits live for exactly one cycle after the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= RESET_CTRL;
    end else if (w_wr_ctrl) begin
      r_ctrl <= bus_i;
    end else begin
      r_ctrl[CT_RXFLUSH] <= 1'b0;
      r_ctrl[CT_TXFLUSH] <= 1'b0;
    end
  end

  // Sticky error flags; a set in the clearing cycle survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~w_done_ctrl);
      r_unf <= w_unf_set | (r_unf & ~w_done_ctrl);
    end
  end

`ifdef AS2650_IO_SENSE_IRQ_EN
  logic r_sense;
  // Interrupt request: RX holds data while enabled, one cycle of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sense <= 1'b0;
    else        r_sense <= r_ctrl[CT_IRQEN] & ~w_rx_empty;
  end
  assign sense_o = r_sense;
  assign w_irq   = r_sense;
`else
  assign w_irq = 1'b0;
`endif

  as2650_io_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_data  (bus_i),
    .i_pop   (w_tx_pop),
    .i_flush (r_ctrl[CT_TXFLUSH]),
    .o_head  (tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  as2650_io_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_data  (w_rx_wdata),
    .i_pop   (w_rx_pop),
    .i_flush (r_ctrl[CT_RXFLUSH]),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

endmodule

// File: tb/tb_as2650_io_responder.sv
// Self-checking bench for as2650_io_responder: a directed vector table, hand
// sequences for multi-cycle corner cases, then random operations against a
// queue-based transaction model. Honours AS2650_IO_SENSE_IRQ_EN.
`timescale 1ns/1ps
module tb_as2650_io_responder;

  localparam int DEPTH = 4;

  typedef enum logic [2:0] {OP_WRC, OP_WRD, OP_RDC, OP_RDD, OP_PUSH, OP_POP} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic [8:0] exp;   // ctrl_q after writes, read byte, push ready, {valid,data} for pop
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bus_i = 8'h00;
  logic [7:0] bus_o;
  logic       bus_oe;
  logic       oe_n = 1'b1;
  logic       we_n = 1'b1;
  logic       ioc = 1'b0;
  logic       iod = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] ctrl_q;
`ifdef AS2650_IO_SENSE_IRQ_EN
  logic       sense_o;
`endif

  int checks = 0;
  int failures = 0;

  // Transaction-level model state
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [7:0] m_ctrl;
  bit         m_ovf, m_unf;

  always #5 clk = ~clk;

  as2650_io_responder #(.DEPTH_LOG2(2), .RESET_CTRL(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_i    (bus_i),
    .bus_o    (bus_o),
    .bus_oe   (bus_oe),
    .oe_n     (oe_n),
    .we_n     (we_n),
    .ioc      (ioc),
    .iod      (iod),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .ctrl_q   (ctrl_q)
`ifdef AS2650_IO_SENSE_IRQ_EN
    ,
    .sense_o  (sense_o)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CPU write: we_n low one cycle, strobe held one more, then idle
  task automatic cpu_write_x(input bit is_ctrl, input logic [7:0] d, input bit pop_tx,
                             input bit push_rx, input logic [7:0] up,
                             output bit rdy_seen, output bit oe_seen);
    ioc = is_ctrl; iod = !is_ctrl; we_n = 1'b0; bus_i = d;
    tx_ready = pop_tx; rx_valid = push_rx; rx_data = up;
    @(negedge clk);
    rdy_seen = rx_ready;
    oe_seen  = bus_oe;
    tick();
    we_n = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    oe_seen = oe_seen | bus_oe;
    tick();
    ioc = 1'b0; iod = 1'b0; bus_i = 8'h00;
    tick();
  endtask

  // CPU read: two oe_n-low cycles, data taken at the end of the second
  task automatic cpu_read(input bit is_ctrl, output logic [7:0] d,
                          output bit oe_both, output bit oe_after);
    bit oe1;
    ioc = is_ctrl; iod = !is_ctrl; oe_n = 1'b0;
    @(negedge clk);
    oe1 = bus_oe;
    tick();
    @(negedge clk);
    oe_both = oe1 & bus_oe;
    d = bus_o;
    tick();
    ioc = 1'b0; iod = 1'b0; oe_n = 1'b1;
    @(negedge clk);
    oe_after = bus_oe;
    tick();
    tick();
  endtask

  task automatic dev_push(input logic [7:0] d, output bit rdy);
    rx_data = d; rx_valid = 1'b1;
    @(negedge clk);
    rdy = rx_ready;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic dev_pop(output bit v, output logic [7:0] d);
    tx_ready = 1'b1;
    @(negedge clk);
    v = tx_valid;
    d = tx_data;
    tick();
    tx_ready = 1'b0;
    tick();
  endtask

  task automatic apply_op(input op_e op, input logic [7:0] d, input logic [8:0] exp, input string tag);
    logic [7:0] rd;
    bit a, b;
    case (op)
      OP_WRC, OP_WRD: begin
        cpu_write_x(op == OP_WRC, d, 1'b0, 1'b0, 8'h00, a, b);
        check({tag, "_wr_oe"}, 32'(b), 32'(0));
        check({tag, "_ctrl"}, 32'(ctrl_q), 32'(exp[7:0]));
      end
      OP_RDC, OP_RDD: begin
        cpu_read(op == OP_RDC, rd, a, b);
        check({tag, "_rd_oe"}, 32'(a), 32'(1));
        check({tag, "_rd_oe_end"}, 32'(b), 32'(0));
        check({tag, "_rd_data"}, 32'(rd), 32'(exp[7:0]));
      end
      OP_PUSH: begin
        dev_push(d, a);
        check({tag, "_rx_ready"}, 32'(a), 32'(exp[0]));
      end
      default: begin
        dev_pop(a, rd);
        check({tag, "_tx_valid"}, 32'(a), 32'(exp[8]));
        if (exp[8]) check({tag, "_tx_data"}, 32'(rd), 32'(exp[7:0]));
      end
    endcase
    $display("txn %s op=%s data=%02h exp=%03h", tag, op.name(), d, exp);
  endtask

  function automatic logic [7:0] m_status();
    logic irq;
    irq = 1'b0;
`ifdef AS2650_IO_SENSE_IRQ_EN
    irq = m_ctrl[7] && (m_rx.size() != 0);
`endif
    return {irq, 1'b0, m_unf, m_ovf, m_tx.size() == DEPTH, m_tx.size() == 0,
            m_rx.size() == DEPTH, m_rx.size() == 0};
  endfunction

  // Reference behaviour of one complete transaction
  task automatic model_step(input op_e op, input logic [7:0] d, output logic [8:0] exp);
    exp = 9'h000;
    case (op)
      OP_WRC: begin
        if (d[1]) m_rx.delete();
        if (d[2]) m_tx.delete();
        m_ctrl = d & 8'hF9;
        exp = {1'b0, m_ctrl};
      end
      OP_WRD: begin
        if (m_ctrl[3]) begin
          if (m_rx.size() < DEPTH) m_rx.push_back(d); else m_ovf = 1'b1;
        end else begin
          if (m_tx.size() < DEPTH) m_tx.push_back(d); else m_ovf = 1'b1;
        end
        exp = {1'b0, m_ctrl};
      end
      OP_RDC: begin
        exp = {1'b0, m_status()};
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      OP_RDD: begin
        if (m_rx.size() != 0) exp = {1'b0, m_rx.pop_front()};
        else m_unf = 1'b1;
      end
      OP_PUSH: begin
        if (m_rx.size() < DEPTH) begin
          m_rx.push_back(d);
          exp = 9'h001;
        end
      end
      default: begin
        if (m_tx.size() != 0) exp = {1'b1, m_tx.pop_front()};
      end
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ioc = 1'b0; iod = 1'b0; oe_n = 1'b1; we_n = 1'b1;
    tx_ready = 1'b0; rx_valid = 1'b0; bus_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_tx.delete(); m_rx.delete();
    m_ctrl = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  vec_t       vecs[$];
  op_e        rop;
  logic [7:0] rdat;
  logic [8:0] rexp;
  bit         s_rdy, s_oe;

  initial begin
    // Directed table
    vecs.push_back('{OP_WRD,  8'h1E, 9'h000});
    vecs.push_back('{OP_WRD,  8'h01, 9'h000});
    vecs.push_back('{OP_WRD,  8'h02, 9'h000});
    vecs.push_back('{OP_WRD,  8'h03, 9'h000});
    vecs.push_back('{OP_WRD,  8'h04, 9'h000});   // dropped, TX already full
    vecs.push_back('{OP_RDC,  8'h00, 9'h019});   // ovf | tx_full | rx_empty
    vecs.push_back('{OP_RDC,  8'h00, 9'h009});   // ovf cleared by previous read
    vecs.push_back('{OP_POP,  8'h00, 9'h11E});
    vecs.push_back('{OP_POP,  8'h00, 9'h101});
    vecs.push_back('{OP_POP,  8'h00, 9'h102});
    vecs.push_back('{OP_POP,  8'h00, 9'h103});
    vecs.push_back('{OP_POP,  8'h00, 9'h000});
    vecs.push_back('{OP_PUSH, 8'h69, 9'h001});
    vecs.push_back('{OP_RDD,  8'h00, 9'h069});
    vecs.push_back('{OP_RDD,  8'h00, 9'h000});   // underflow
    vecs.push_back('{OP_RDC,  8'h00, 9'h025});   // unf | tx_empty | rx_empty
    vecs.push_back('{OP_WRC,  8'h08, 9'h008});   // loopback on
    vecs.push_back('{OP_WRD,  8'h89, 9'h008});
    vecs.push_back('{OP_RDD,  8'h00, 9'h089});
    vecs.push_back('{OP_POP,  8'h00, 9'h000});   // TX untouched
    vecs.push_back('{OP_WRC,  8'h00, 9'h000});
    vecs.push_back('{OP_RDC,  8'h00, 9'h005});

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus_oe", 32'(bus_oe), 32'(0));
    check("rst_bus_o", 32'(bus_o), 32'(0));
    check("rst_tx_valid", 32'(tx_valid), 32'(0));
    check("rst_rx_ready", 32'(rx_ready), 32'(1));
    check("rst_ctrl", 32'(ctrl_q), 32'(8'h00));
`ifdef AS2650_IO_SENSE_IRQ_EN
    check("rst_sense", 32'(sense_o), 32'(0));
`endif
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) apply_op(vecs[i].op, vecs[i].data, vecs[i].exp, "vec");

    // WRTC 0x0A with we_n held low a second cycle: only the first edge commits
    ioc = 1'b1; we_n = 1'b0; bus_i = 8'h0A;
    @(negedge clk);
    check("wrc0a_oe_c1", 32'(bus_oe), 32'(0));
    tick();
    bus_i = 8'h55;
    @(negedge clk);
    check("wrc0a_ctrl_c1", 32'(ctrl_q), 32'(8'h0A));
    check("wrc0a_oe_c2", 32'(bus_oe), 32'(0));
    tick();
    we_n = 1'b1;
    @(negedge clk);
    check("wrc0a_ctrl_c2", 32'(ctrl_q), 32'(8'h08));
    tick();
    ioc = 1'b0; bus_i = 8'h00;
    tick();
    $display("txn seq wrc0a done");
    apply_op(OP_WRC, 8'h00, 9'h000, "restore");

    // Illegal cycle: both strobes high
    ioc = 1'b1; iod = 1'b1; we_n = 1'b0; bus_i = 8'hFF;
    @(negedge clk);
    check("illegal_wr_oe", 32'(bus_oe), 32'(0));
    tick();
    we_n = 1'b1; oe_n = 1'b0;
    @(negedge clk);
    check("illegal_rd_oe", 32'(bus_oe), 32'(0));
    tick();
    ioc = 1'b0; iod = 1'b0; oe_n = 1'b1; bus_i = 8'h00;
    tick(); tick();
    check("illegal_ctrl", 32'(ctrl_q), 32'(8'h00));
    check("illegal_tx_valid", 32'(tx_valid), 32'(0));
    $display("txn seq illegal done");
    apply_op(OP_RDC, 8'h00, 9'h005, "illegal");

    // Empty TX: pop and push in the same cycle, pop ignored
    cpu_write_x(1'b0, 8'h42, 1'b1, 1'b0, 8'h00, s_rdy, s_oe);
    check("emptypp_tx_valid", 32'(tx_valid), 32'(1));
    check("emptypp_tx_data", 32'(tx_data), 32'(8'h42));
    apply_op(OP_POP, 8'h00, 9'h142, "emptypp");

    // Full TX: pop frees a slot for a same-cycle push
    for (int i = 0; i < DEPTH; i++) apply_op(OP_WRD, 8'(8'hA0 + i), 9'h000, "fill");
    cpu_write_x(1'b0, 8'hAA, 1'b1, 1'b0, 8'h00, s_rdy, s_oe);
    $display("txn seq fullpp done");
    apply_op(OP_RDC, 8'h00, 9'h009, "fullpp");
    apply_op(OP_POP, 8'h00, 9'h1A1, "fullpp");
    apply_op(OP_POP, 8'h00, 9'h1A2, "fullpp");
    apply_op(OP_POP, 8'h00, 9'h1A3, "fullpp");
    apply_op(OP_POP, 8'h00, 9'h1AA, "fullpp");
    apply_op(OP_POP, 8'h00, 9'h000, "fullpp");

    // Loopback write colliding with an upstream push: CPU byte wins
    apply_op(OP_WRC, 8'h08, 9'h008, "coll");
    cpu_write_x(1'b0, 8'h77, 1'b0, 1'b1, 8'h33, s_rdy, s_oe);
    check("coll_rx_ready", 32'(s_rdy), 32'(0));
    apply_op(OP_RDD, 8'h00, 9'h077, "coll");
    apply_op(OP_RDD, 8'h00, 9'h000, "coll");
    apply_op(OP_RDC, 8'h00, 9'h025, "coll");
    apply_op(OP_WRC, 8'h00, 9'h000, "coll");

`ifdef AS2650_IO_SENSE_IRQ_EN
    // Interrupt output follows RX occupancy one cycle late
    apply_op(OP_WRC, 8'h80, 9'h080, "irq");
    rx_data = 8'h11; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    @(negedge clk);
    check("irq_sense_lat", 32'(sense_o), 32'(0));
    tick();
    @(negedge clk);
    check("irq_sense_set", 32'(sense_o), 32'(1));
    tick();
    apply_op(OP_RDC, 8'h00, 9'h084, "irq");
    apply_op(OP_RDD, 8'h00, 9'h011, "irq");
    check("irq_sense_clr", 32'(sense_o), 32'(0));
    apply_op(OP_WRC, 8'h00, 9'h000, "irq");
`endif

    // Reset in the middle of a data read
    apply_op(OP_PUSH, 8'h5A, 9'h001, "rstmid");
    iod = 1'b1; oe_n = 1'b0;
    @(negedge clk);
    check("rstmid_oe", 32'(bus_oe), 32'(1));
    check("rstmid_data", 32'(bus_o), 32'(8'h5A));
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_oe_async", 32'(bus_oe), 32'(0));
    check("rstmid_bus_o", 32'(bus_o), 32'(0));
    tick();
    iod = 1'b0; oe_n = 1'b1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rstmid_rx_ready", 32'(rx_ready), 32'(1));
    check("rstmid_ctrl", 32'(ctrl_q), 32'(8'h00));
    $display("txn seq rstmid done");
    apply_op(OP_RDC, 8'h00, 9'h005, "rstmid");

    // Random operations against the model
    do_reset();
    for (int i = 0; i < 250; i++) begin
      rop  = op_e'($urandom_range(0, 5));
      rdat = 8'($urandom);
      if (rop == OP_WRC && $urandom_range(0, 3) != 0) rdat[2:1] = 2'b00;
      model_step(rop, rdat, rexp);
      apply_op(rop, rdat, rexp, "rnd");
      check("rnd_tx_valid", 32'(tx_valid), 32'(m_tx.size() != 0));
      check("rnd_ctrl_now", 32'(ctrl_q), 32'(m_ctrl));
`ifdef AS2650_IO_SENSE_IRQ_EN
      check("rnd_sense", 32'(sense_o), 32'(m_ctrl[7] && (m_rx.size() != 0)));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
